// File: rtl/tick_sched_pkg.sv
// Shared types and constants for the tick scheduler: channel state encoding,
// the default prescaler divisor for a 100 Hz tick at 50 MHz, and default counter width.
package tick_sched_pkg;

    typedef enum logic [1:0] {
        CH_IDLE    = 2'd0,
        CH_ARMED   = 2'd1,
        CH_PENDING = 2'd2
    } ch_state_e;

    localparam int DIV_100HZ     = 500000;
    localparam int DEFAULT_CNT_W = 16;

endpackage

// File: rtl/tick_scheduler_rr_arbiter.sv
// Round-robin arbiter: grants the lowest-index request at or after the rotating pointer,
// and moves the pointer to one past the granted index.
module rr_arbiter #(
    parameter int NCH = 4
) (
    input  logic                   CLK,
    input  logic                   reset,
    input  logic [NCH-1:0]         req,
    input  logic                   en,
    output logic [NCH-1:0]         grant,
    output logic [$clog2(NCH)-1:0] grant_idx,
    output logic                   grant_valid
);

    localparam int IW = $clog2(NCH);

    logic [IW-1:0]  ptr_reg;
    logic [IW-1:0]  ptr_next;
    logic [NCH-1:0] rot;
    logic [IW-1:0]  off;
    logic [IW:0]    sum;
    logic           found;

    // Rotate requests so bit 0 corresponds to the pointer position.
    assign rot = NCH'({req, req} >> ptr_reg);

    always_comb begin
        found = 1'b0;
        off   = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            if (rot[k]) begin
                found = 1'b1;
                off   = IW'(k);
            end
        end
        sum = {1'b0, ptr_reg} + {1'b0, off};
        if (sum >= (IW + 1)'(NCH)) begin
            sum = sum - (IW + 1)'(NCH);
        end
        grant_idx   = sum[IW-1:0];
        grant_valid = en & found;
        grant       = grant_valid ? (NCH'(1) << grant_idx) : '0;
        ptr_next    = (grant_idx == IW'(NCH - 1)) ? '0 : grant_idx + 1'b1;
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            ptr_reg <= '0;
        end else if (grant_valid) begin
            ptr_reg <= ptr_next;
        end
    end

endmodule

// File: rtl/tick_scheduler.sv
// Multi-channel countdown scheduler with a tick prescaler and a round-robin event port.
// Define TICK_SCHED_AUTORELOAD_EN for periodic channels with sticky overrun flags.
module tick_scheduler
    import tick_sched_pkg::*;
#(
    parameter int NCH   = 4,
    parameter int CNT_W = DEFAULT_CNT_W,
    parameter int DIV   = DIV_100HZ
) (
    input  logic                   CLK,
    input  logic                   reset,
    output logic                   tick_o,
    input  logic                   ld_valid,
    input  logic [$clog2(NCH)-1:0] ld_ch,
    input  logic [CNT_W-1:0]       ld_count,
    output logic                   evt_valid,
    output logic [$clog2(NCH)-1:0] evt_ch,
    input  logic                   evt_ready,
    output logic [NCH-1:0]         armed_o,
    output logic [NCH-1:0]         overrun_o
);

    localparam int IW = $clog2(NCH);
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [PW-1:0]  presc_reg;
    logic [NCH-1:0] pend;
    logic [NCH-1:0] ld_hit;
    logic [NCH-1:0] grant;
    logic [IW-1:0]  grant_idx;
    logic           grant_valid;
    logic           grant_en;
    logic           evt_valid_reg;
    logic [IW-1:0]  evt_ch_reg;

    assign tick_o = (presc_reg == PW'(DIV - 1));

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            presc_reg <= '0;
        end else if (tick_o) begin
            presc_reg <= '0;
        end else begin
            presc_reg <= presc_reg + 1'b1;
        end
    end

    genvar gi;
    for (gi = 0; gi < NCH; gi++) begin : g_ch
        ch_state_e        state_reg;
        logic [CNT_W-1:0] count_reg;

        assign ld_hit[gi]  = ld_valid && (ld_ch == IW'(gi));
        assign pend[gi]    = (state_reg == CH_PENDING);
        assign armed_o[gi] = (state_reg != CH_IDLE);

`ifdef TICK_SCHED_AUTORELOAD_EN
        logic [CNT_W-1:0] reload_reg;
        logic             overrun_reg;

        assign overrun_o[gi] = overrun_reg;

        always_ff @(posedge CLK or negedge reset) begin
            if (!reset) begin
                state_reg   <= CH_IDLE;
                count_reg   <= '0;
                reload_reg  <= '0;
                overrun_reg <= 1'b0;
            end else if (ld_hit[gi]) begin
                state_reg   <= (ld_count == '0) ? CH_IDLE : CH_ARMED;
                count_reg   <= ld_count;
                reload_reg  <= ld_count;
                overrun_reg <= 1'b0;
            end else if (state_reg != CH_IDLE && tick_o && count_reg == CNT_W'(1)) begin
                // Expiry wins over a coincident grant: the new event stays queued.
                count_reg <= reload_reg;
                state_reg <= CH_PENDING;
                if (state_reg == CH_PENDING && !grant[gi]) begin
                    overrun_reg <= 1'b1;
                end
            end else begin
                if (state_reg != CH_IDLE && tick_o) begin
                    count_reg <= count_reg - 1'b1;
                end
                if (grant[gi]) begin
                    state_reg <= CH_ARMED;
                end
            end
        end
`else
        assign overrun_o[gi] = 1'b0;

        always_ff @(posedge CLK or negedge reset) begin
            if (!reset) begin
                state_reg <= CH_IDLE;
                count_reg <= '0;
            end else if (ld_hit[gi]) begin
                state_reg <= (ld_count == '0) ? CH_IDLE : CH_ARMED;
                count_reg <= ld_count;
            end else if (grant[gi]) begin
                state_reg <= CH_IDLE;
            end else if (state_reg == CH_ARMED && tick_o) begin
                count_reg <= count_reg - 1'b1;
                if (count_reg == CNT_W'(1)) begin
                    state_reg <= CH_PENDING;
                end
            end
        end
`endif
    end

    // A channel being reloaded this cycle is withheld from the arbiter so the load wins.
    assign grant_en = !evt_valid_reg || evt_ready;

    rr_arbiter #(.NCH(NCH)) u_arb (
        .CLK         (CLK),
        .reset       (reset),
        .req         (pend & ~ld_hit),
        .en          (grant_en),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            evt_valid_reg <= 1'b0;
            evt_ch_reg    <= '0;
        end else if (grant_en) begin
            evt_valid_reg <= grant_valid;
            if (grant_valid) begin
                evt_ch_reg <= grant_idx;
            end
        end
    end

    assign evt_valid = evt_valid_reg;
    assign evt_ch    = evt_ch_reg;

endmodule

// File: tb/tb_tick_scheduler.sv
// Self-checking bench for tick_scheduler (DIV=4): directed scenarios plus random traffic,
// compared every cycle against a tick-count reference model.
module tb_tick_scheduler;

    localparam int NCH   = 4;
    localparam int CNT_W = 16;
    localparam int DIV   = 4;

    logic             CLK = 1'b0;
    logic             reset = 1'b0;
    logic             tick_o;
    logic             ld_valid = 1'b0;
    logic [1:0]       ld_ch = '0;
    logic [CNT_W-1:0] ld_count = '0;
    logic             evt_valid;
    logic [1:0]       evt_ch;
    logic             evt_ready = 1'b0;
    logic [NCH-1:0]   armed_o;
    logic [NCH-1:0]   overrun_o;

    int checks = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    tick_scheduler #(.NCH(NCH), .CNT_W(CNT_W), .DIV(DIV)) dut (
        .CLK       (CLK),
        .reset     (reset),
        .tick_o    (tick_o),
        .ld_valid  (ld_valid),
        .ld_ch     (ld_ch),
        .ld_count  (ld_count),
        .evt_valid (evt_valid),
        .evt_ch    (evt_ch),
        .evt_ready (evt_ready),
        .armed_o   (armed_o),
        .overrun_o (overrun_o)
    );

    // Reference model: ticks remaining per channel, queued-event flag, overrun flag,
    // plus the presented event and the round-robin start position.
    int m_cycle;
    int m_rem [NCH];
    int m_rel [NCH];
    bit m_pend[NCH];
    bit m_ovr [NCH];
    bit m_valid;
    int m_ch;
    int m_ptr;

    task automatic m_reset();
        m_cycle = 0;
        for (int c = 0; c < NCH; c++) begin
            m_rem[c] = 0; m_rel[c] = 0; m_pend[c] = 0; m_ovr[c] = 0;
        end
        m_valid = 0; m_ch = 0; m_ptr = 0;
    endtask

    task automatic m_step();
        bit tick;
        int gnt;
        tick = (m_cycle % DIV) == DIV - 1;
        gnt = -1;
        if (!m_valid || evt_ready) begin
            for (int k = 0; k < NCH; k++) begin
                if (gnt < 0 && m_pend[(m_ptr + k) % NCH] &&
                    !(ld_valid && int'(ld_ch) == (m_ptr + k) % NCH))
                    gnt = (m_ptr + k) % NCH;
            end
            m_valid = (gnt >= 0);
            if (gnt >= 0) begin
                m_ch = gnt;
                m_ptr = (gnt + 1) % NCH;
            end
        end
        for (int c = 0; c < NCH; c++) begin
            if (ld_valid && int'(ld_ch) == c) begin
                m_rem[c] = int'(ld_count); m_rel[c] = int'(ld_count);
                m_pend[c] = 0; m_ovr[c] = 0;
            end else begin
`ifdef TICK_SCHED_AUTORELOAD_EN
                if (gnt == c) m_pend[c] = 0;
                if (tick && m_rel[c] != 0) begin
                    m_rem[c] = m_rem[c] - 1;
                    if (m_rem[c] == 0) begin
                        m_rem[c] = m_rel[c];
                        if (m_pend[c]) m_ovr[c] = 1;
                        m_pend[c] = 1;
                    end
                end
`else
                if (gnt == c) m_pend[c] = 0;
                else if (!m_pend[c] && m_rem[c] > 0 && tick) begin
                    m_rem[c] = m_rem[c] - 1;
                    if (m_rem[c] == 0) m_pend[c] = 1;
                end
`endif
            end
        end
        m_cycle++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, m_cycle);
        end
    endtask

    task automatic check_all();
        logic [NCH-1:0] arm;
        logic [NCH-1:0] ovr;
        for (int c = 0; c < NCH; c++) begin
`ifdef TICK_SCHED_AUTORELOAD_EN
            arm[c] = (m_rel[c] != 0);
`else
            arm[c] = (m_rem[c] > 0) || m_pend[c];
`endif
            ovr[c] = m_ovr[c];
        end
        check("tick_o", 32'(tick_o), 32'((m_cycle % DIV) == DIV - 1));
        check("evt_valid", 32'(evt_valid), 32'(m_valid));
        if (m_valid) check("evt_ch", 32'(evt_ch), m_ch);
        check("armed_o", 32'(armed_o), 32'(arm));
        check("overrun_o", 32'(overrun_o), 32'(ovr));
    endtask

    // One clock: drive inputs, advance the model, then sample 1 time unit after the edge.
    task automatic step(input bit v, input int ch, input int cnt, input bit rdy);
        ld_valid = v; ld_ch = 2'(ch); ld_count = CNT_W'(cnt); evt_ready = rdy;
        m_step();
        @(posedge CLK);
        #1;
        check_all();
    endtask

    int q_ch[$];
    int q_cyc[$];
    int seen;
    int t1;
    int t_load;
    bit any_evt;

    initial begin
        m_reset();
        repeat (2) @(posedge CLK);
        #1;
        check("rst_evt_ch", 32'(evt_ch), 0);
        check_all();
        reset = 1'b1;

        // Single one-shot channel: latency from load to event
        while (m_cycle % DIV != 1) step(0, 0, 0, 0);
        t_load = m_cycle;
        step(1, 0, 3, 0);
        t1 = t_load + 1;
        while (t1 % DIV != DIV - 1) t1++;
        seen = -1;
        for (int n = 0; n < 40 && seen < 0; n++) begin
            if (evt_valid === 1'b1) seen = m_cycle;
            else step(0, 0, 0, 0);
        end
        check("ch0_latency", seen, t1 + 2 * DIV + 2);
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        check("ch0_disarmed", 32'(armed_o[0]), 0);

        // Three channels expiring on the same tick drain on consecutive cycles
        while (m_cycle % DIV != 0) step(0, 0, 0, 1);
        step(1, 1, 2, 1);
        step(1, 2, 2, 1);
        step(1, 3, 2, 1);
        for (int n = 0; n < 20; n++) begin
            if (evt_valid === 1'b1) begin
                q_ch.push_back(int'(evt_ch));
                q_cyc.push_back(m_cycle);
            end
            step(0, 0, 0, 1);
        end
        check("b2b_count", q_ch.size(), 3);
        if (q_ch.size() == 3) begin
            check("b2b_first", q_ch[0], 1);
            check("b2b_second", q_ch[1], 2);
            check("b2b_third", q_ch[2], 3);
            check("b2b_span", q_cyc[2] - q_cyc[0], 2);
        end

        // Event held stable while consumer stalls
        step(1, 2, 1, 0);
        for (int n = 0; n < 20 && evt_valid !== 1'b1; n++) step(0, 0, 0, 0);
        check("stall_valid", 32'(evt_valid), 1);
        for (int n = 0; n < 10; n++) begin
            step(0, 0, 0, 0);
            check("stall_ch", 32'(evt_ch), 2);
        end
        step(0, 0, 0, 1);

        // Disarm mid-countdown
        step(1, 2, 5, 1);
        repeat (2 * DIV) step(0, 0, 0, 1);
        step(1, 2, 0, 1);
        any_evt = 0;
        for (int n = 0; n < 30; n++) begin
            step(0, 0, 0, 1);
            if (evt_valid === 1'b1) any_evt = 1;
        end
        check("disarm_no_evt", 32'(any_evt), 0);
        check("disarm_armed2", 32'(armed_o[2]), 0);

`ifdef TICK_SCHED_AUTORELOAD_EN
        // Periodic channel overruns while the consumer stalls
        step(1, 0, 2, 0);
        repeat (6 * DIV) step(0, 0, 0, 0);
        check("ovr_set", 32'(overrun_o[0]), 1);
        step(1, 0, 0, 0);
        check("ovr_clr", 32'(overrun_o[0]), 0);
        repeat (3) step(0, 0, 0, 1);
`endif

        // Reset in the middle of a presented event
        step(1, 1, 1, 0);
        for (int n = 0; n < 20 && evt_valid !== 1'b1; n++) step(0, 0, 0, 0);
        step(1, 3, 3, 0);
        #2;
        reset = 1'b0;
        #1;
        check("rst_mid_valid", 32'(evt_valid), 0);
        check("rst_mid_armed", 32'(armed_o), 0);
        check("rst_mid_ovr", 32'(overrun_o), 0);
        check("rst_mid_tick", 32'(tick_o), 0);
        @(posedge CLK);
        #1;
        m_reset();
        reset = 1'b1;
        check_all();
        for (int n = 0; n < 20; n++) step(0, 0, 0, 1);

        // Random traffic
        for (int n = 0; n < 500; n++) begin
            step(($urandom % 6) == 0, int'($urandom % NCH), int'($urandom_range(0, 5)),
                 ($urandom % 3) != 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tick_scheduler.md
# tick_scheduler

Multi-channel countdown scheduler driven by an internal 100 Hz tick prescaler; the game's central source of timed events (sprite step, debounce windows, round timers). Each channel is armed with a tick count, counts down on every tick strobe, and on expiry queues an event. A round-robin arbiter presents expired channels one at a time on a valid/ready event port to the game logic, so one consumer serves all timers.

## Interface
- `NCH`, 4: number of timer channels (2..16)
- `CNT_W`, 16: countdown width in ticks
- `DIV`, 500000: CLK cycles per tick (100 Hz at 50 MHz)
- `CLK`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `tick_o`  out  1  one-cycle strobe every `DIV` cycles
- `ld_valid`  in  1  load command strobe
- `ld_ch`  in  $clog2(NCH)  channel addressed by load
- `ld_count`  in  CNT_W  ticks until expiry; 0 disarms channel
- `evt_valid`  out  1  event presented
- `evt_ch`  out  $clog2(NCH)  channel of presented event
- `evt_ready`  in  1  consumer accepts event
- `armed_o`  out  NCH  per-channel armed bitmap
- `overrun_o`  out  NCH  sticky per-channel overrun flags

## Operation
- Prescaler: counter 0..DIV-1; `tick_o`=1 in the cycle counter==DIV-1, then wraps to 0.
- Channel states: IDLE, ARMED, PENDING. Per channel: count register, reload register, pending bit.
- Load (`ld_valid`): channel ← ARMED, count=reload=`ld_count`, pending cleared, overrun cleared; `ld_count`=0 → IDLE. Load overrides everything else on that channel in the same cycle (including a coincident tick or arbiter capture).
- ARMED on `tick_o`: count==1 → PENDING; else count−1.
- Arbiter: when output register empty or draining (`evt_valid & evt_ready`), grant lowest-index pending channel at or after the last granted+1 (wrap); granted channel's pending bit clears, channel leaves PENDING (→ IDLE, or per Configuration), channel index captured into output register.
- `evt_valid`/`evt_ch` stable while `evt_valid & !evt_ready`; never withdrawn.
- `armed_o[i]`=1 in ARMED or PENDING.
- Out-of-range `ld_ch` (≥NCH): ignored.

## Timing
- Reset: prescaler 0, all channels IDLE, counts/reloads 0, `tick_o`=0, `evt_valid`=0, `evt_ch`=0, `armed_o`=0, `overrun_o`=0, RR pointer 0.
- Load at cycle t visible at t+1; a tick in cycle t does not decrement the newly loaded value.
- Load N → PENDING on the Nth tick after the load; `evt_valid` earliest the cycle after PENDING is entered.
- Back-to-back: with `evt_ready` held 1, one event per cycle.
- Reset mid-operation: immediate return to reset values; in-flight event lost.

## Configuration
- `TICK_SCHED_AUTORELOAD_EN` defined: expiry reloads count from reload register and channel stays counting (periodic); granted channel returns to ARMED, not IDLE. If a channel expires again while its pending bit is still set, pending stays 1 (one event) and `overrun_o[i]` sets sticky until next load.
- Undefined: one-shot; granted channel → IDLE; PENDING channels do not count; `overrun_o` tied 0.

## Structure
- Package `tick_sched_pkg`: channel state enum (IDLE/ARMED/PENDING), `DIV_100HZ` constant (500000), default `CNT_W`.
- Sub-module `rr_arbiter` (NCH request vector, grant enable, one-hot grant + index, rotating pointer).

## Test plan
- DIV=4, load ch0 N=3 → `tick_o` every 4 cycles; `evt_valid` with `evt_ch`=0 one cycle after 3rd tick; `armed_o[0]` falls after handshake (one-shot).
- Load ch1..ch3 N=2 same interval, `evt_ready`=1 → events ch1,ch2,ch3 on consecutive cycles.
- `evt_ready`=0 for 10 cycles with event pending → `evt_valid`/`evt_ch` unchanged all 10 cycles; accepted on ready.
- Load ch2 N=5, reload ch2 N=0 after 2 ticks → no event, `armed_o[2]`=0.
- Autoreload build, ch0 N=2, `evt_ready`=0 for 6 ticks → single event, `overrun_o[0]`=1; load ch0 clears it.
- Assert `reset` low mid-countdown with event valid → all outputs 0 next sample, no event after release.
